// File: rtl/gate_reduce_pipe.sv
// gate_reduce_pipe: a registered multi-input bitwise gate with valid/ready handshakes.
// It reduces INPUTS operands of WIDTH bits each using OR, AND or XOR, optionally
// inverts the result, and applies a per-operand participation mask.
// Data passes through two stages: stage A holds the op and the masked operands,
// and stage B holds the result.
// Optional build macro GATE_REDUCE_PIPE_ZERO_FLAG_EN adds the out_zero output.
module gate_reduce_pipe #(
  parameter int WIDTH  = 8,
  parameter int INPUTS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [INPUTS-1:0]        in_mask,
  input  logic [INPUTS*WIDTH-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_err
`ifdef GATE_REDUCE_PIPE_ZERO_FLAG_EN
  ,
  output logic                     out_zero
`endif
);

  typedef enum logic [2:0] {
    OP_OR   = 3'd0,
    OP_AND  = 3'd1,
    OP_XOR  = 3'd2,
    OP_NOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_XNOR = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } op_e;

  // Stage A state
  logic                    a_valid_q, a_valid_d;
  op_e                     a_op_q, a_op_d;
  logic [INPUTS*WIDTH-1:0] a_data_q, a_data_d;

  // Stage B state (drives the outputs)
  logic                    out_valid_q, out_valid_d;
  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic                    out_err_q, out_err_d;
`ifdef GATE_REDUCE_PIPE_ZERO_FLAG_EN
  logic                    out_zero_q, out_zero_d;
`endif

  // Handshake and datapath intermediates
  logic                    b_free, a_free, a_load, b_load;
  op_e                     in_op_e;
  logic [WIDTH-1:0]        ident;
  logic [INPUTS*WIDTH-1:0] sub_data;
  logic [WIDTH-1:0]        red_or, red_and, red_xor;
  logic [WIDTH-1:0]        res_data;
  logic                    res_err;

  assign in_op_e = op_e'(in_op);

  // Advance rules: in_ready depends only on registered state and out_ready.
  always_comb begin
    b_free   = !out_valid_q || out_ready;
    a_free   = !a_valid_q || b_free;
    b_load   = a_valid_q && b_free;
    a_load   = in_valid && a_free;
    in_ready = a_free;
  end

  // Replace each masked-off operand with the identity of the base function.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    sub_data = '0;
    ident    = ((in_op_e == OP_AND) || (in_op_e == OP_NAND)) ? '1 : '0;
    for (int k = 0; k < INPUTS; k++) begin
      sub_data[k*WIDTH +: WIDTH] = in_mask[k] ? in_data[k*WIDTH +: WIDTH] : ident;
    end
  end

  // Reduce the stage A operands, then select and optionally invert the result by op.
  always_comb begin
    red_or   = '0;
    red_and  = '1;
    red_xor  = '0;
    for (int k = 0; k < INPUTS; k++) begin
      red_or  = red_or  | a_data_q[k*WIDTH +: WIDTH];
      red_and = red_and & a_data_q[k*WIDTH +: WIDTH];
      red_xor = red_xor ^ a_data_q[k*WIDTH +: WIDTH];
    end
    res_data = '0;
    res_err  = 1'b0;
    case (a_op_q)
      OP_OR:   res_data = red_or;
      OP_AND:  res_data = red_and;
      OP_XOR:  res_data = red_xor;
      OP_NOR:  res_data = ~red_or;
      OP_NAND: res_data = ~red_and;
      OP_XNOR: res_data = ~red_xor;
      default: res_err  = 1'b1;
    endcase
  end

  // Next state for both stages: load on advance, otherwise hold or drain.
  always_comb begin
    a_valid_d   = a_load ? 1'b1 : (b_load ? 1'b0 : a_valid_q);
    a_op_d      = a_load ? in_op_e : a_op_q;
    a_data_d    = a_load ? sub_data : a_data_q;
    out_valid_d = b_load ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_data_d  = b_load ? res_data : out_data_q;
    out_err_d   = b_load ? res_err : out_err_q;
`ifdef GATE_REDUCE_PIPE_ZERO_FLAG_EN
    out_zero_d  = b_load ? (res_data == '0) : out_zero_q;
`endif
  end

  // Pipeline registers; reset discards any data in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      a_valid_q   <= 1'b0;
      a_op_q      <= OP_OR;
      a_data_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
`ifdef GATE_REDUCE_PIPE_ZERO_FLAG_EN
      out_zero_q  <= 1'b0;
`endif
    end else begin
      a_valid_q   <= a_valid_d;
      a_op_q      <= a_op_d;
      a_data_q    <= a_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
`ifdef GATE_REDUCE_PIPE_ZERO_FLAG_EN
      out_zero_q  <= out_zero_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
`ifdef GATE_REDUCE_PIPE_ZERO_FLAG_EN
  assign out_zero  = out_zero_q;
`endif

endmodule

// File: tb/tb_gate_reduce_pipe.sv
// Self-checking bench for gate_reduce_pipe (WIDTH=8, INPUTS=4).
// A queue-based scoreboard holds the expected results, and a behavioural reduction
// model supplies the expected values.
module tb_gate_reduce_pipe;

  localparam int W = 8;
  localparam int N = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic         err;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     in_op;
  logic [N-1:0]   in_mask;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_err;
`ifdef GATE_REDUCE_PIPE_ZERO_FLAG_EN
  logic           out_zero;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  gate_reduce_pipe #(.WIDTH(W), .INPUTS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_mask   (in_mask),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
`ifdef GATE_REDUCE_PIPE_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  always #5 clk = ~clk;

  // The function code picks a base reduction and an optional inversion.
  // Masked-off operands are skipped, so they act as the identity of the reduction.
  function automatic exp_t ref_model(input logic [2:0] op, input logic [N-1:0] m,
                                     input logic [N*W-1:0] d);
    exp_t         r;
    logic [W-1:0] acc;
    logic [W-1:0] opnd;
    int           base;
    r.err  = (op >= 3'd6);
    r.data = '0;
    if (!r.err) begin
      base = int'(op) % 3;
      acc  = (base == 1) ? '1 : '0;
      for (int k = 0; k < N; k++) begin
        opnd = d[k*W +: W];
        if (m[k]) begin
          if (base == 0)      acc = acc | opnd;
          else if (base == 1) acc = acc & opnd;
          else                acc = acc ^ opnd;
        end
      end
      r.data = (op >= 3'd3) ? ~acc : acc;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle. Inputs are driven at negedge, and sampling happens 1 time unit later.
  // An accepted input pushes its expected result; a delivered output is compared against the queue head.
  task automatic drive(input logic v, input logic [2:0] op, input logic [N-1:0] m,
                       input logic [N*W-1:0] d, input logic ordy);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in_op     = op;
    in_mask   = m;
    in_data   = d;
    out_ready = ordy;
    #1;
    if (in_valid && in_ready) exp_q.push_back(ref_model(op, m, d));
    if (out_valid && out_ready) begin
      check("result_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_data", 64'(out_data), 64'(e.data));
        check("sb_err", 64'(out_err), 64'(e.err));
`ifdef GATE_REDUCE_PIPE_ZERO_FLAG_EN
        check("sb_zero", 64'(out_zero), 64'(e.data == '0));
`endif
      end
    end
  endtask

  // A single transfer into an idle pipeline: no result after the first edge, the result after the second.
  task automatic single(input string tag, input logic [2:0] op, input logic [N-1:0] m,
                        input logic [N*W-1:0] d, input logic [W-1:0] exp_data,
                        input logic exp_err);
    drive(1'b1, op, m, d, 1'b1);
    drive(1'b0, 3'd0, '0, '0, 1'b1);
    check({tag, "_lat1"}, 64'(out_valid), 64'(0));
    drive(1'b0, 3'd0, '0, '0, 1'b1);
    check({tag, "_lat2"}, 64'(out_valid), 64'(1));
    check({tag, "_data"}, 64'(out_data), 64'(exp_data));
    check({tag, "_err"}, 64'(out_err), 64'(exp_err));
  endtask

  initial begin
    logic [W-1:0] held_data;
    logic         held_err;

    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_mask = '0; in_data = '0; out_ready = 1'b1;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_err", 64'(out_err), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Directed cases from the test plan
    single("or_f",     3'd0, 4'hF,    32'h08040201, 8'h0F, 1'b0);
    single("and_e",    3'd1, 4'b1110, 32'h3CFFF000, 8'h30, 1'b0);
    single("and_0",    3'd1, 4'h0,    32'h3CFFF000, 8'hFF, 1'b0);
    single("xnor_f",   3'd5, 4'hF,    32'h00FF55AA, 8'hFF, 1'b0);
    single("rsv6",     3'd6, 4'hF,    32'hDEADBEEF, 8'h00, 1'b1);
    single("nand_0",   3'd4, 4'h0,    32'h12345678, 8'h00, 1'b0);
    single("nor_0",    3'd3, 4'h0,    32'h12345678, 8'hFF, 1'b0);
`ifdef GATE_REDUCE_PIPE_ZERO_FLAG_EN
    single("rsv7",     3'd7, 4'h5,    32'h0,        8'h00, 1'b1);
    check("rsv7_zero", 64'(out_zero), 64'(1));
`endif

    // Six back-to-back inputs at full rate: one result on every cycle, in order
    for (int i = 0; i < 8; i++) begin
      drive(i < 6, 3'($urandom_range(0, 7)), 4'($urandom), $urandom, 1'b1);
      if (i >= 2) check("stream_valid", 64'(out_valid), 64'(1));
    end
    drive(1'b0, 3'd0, '0, '0, 1'b1);
    check("stream_drained", 64'(exp_q.size()), 64'(0));

    // Backpressure: only two inputs are accepted and the output holds stable
    held_data = '0;
    held_err  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'($urandom_range(0, 5)), 4'($urandom), $urandom, 1'b0);
      check("bp_in_ready", 64'(in_ready), 64'(i < 2));
      if (i == 2) begin
        held_data = out_data;
        held_err  = out_err;
      end
      if (i >= 2) begin
        check("bp_valid", 64'(out_valid), 64'(1));
        check("bp_data_hold", 64'(out_data), 64'(held_data));
        check("bp_err_hold", 64'(out_err), 64'(held_err));
      end
    end
    check("bp_queued", 64'(exp_q.size()), 64'(2));
    for (int i = 0; i < 3; i++) drive(1'b0, 3'd0, '0, '0, 1'b1);
    check("bp_drained", 64'(exp_q.size()), 64'(0));

    // Random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), 3'($urandom_range(0, 7)), 4'($urandom), $urandom,
            1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 3'd0, '0, '0, 1'b1);
    check("rand_drained", 64'(exp_q.size()), 64'(0));

    // Asynchronous reset with the pipeline full
    drive(1'b1, 3'd1, 4'hF, 32'hFFFFFFFF, 1'b0);
    drive(1'b1, 3'd0, 4'hF, 32'h01010101, 1'b0);
    drive(1'b0, 3'd0, '0, '0, 1'b0);
    check("full_before_rst", 64'(out_valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'(0));
    check("arst_data", 64'(out_data), 64'(0));
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'd0, '0, '0, 1'b1);
      check("post_rst_ready", 64'(in_ready), 64'(1));
      check("post_rst_no_stale", 64'(out_valid), 64'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
